// File: rtl/input_unit_if.sv
`default_nettype none
// ============================================================================
// input_unit_if : flit, route-computation and allocator signals of one input
// Rev 1.0
// ============================================================================
interface input_unit_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
);
  logic                       in_valid;
  logic [FLIT_W-1:0]          in_flit;
  logic                       credit_out;
  logic [2:0]                 dst_x;
  logic [2:0]                 dst_y;
  logic [2:0]                 route_sel;
  logic                       req_valid;
  logic [2:0]                 req_port;
  logic                       grant;
  logic                       out_valid;
  logic [FLIT_W-1:0]          out_flit;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [1:0]                 err;

  modport slave (
    input  in_valid, in_flit, route_sel, grant,
    output credit_out, dst_x, dst_y, req_valid, req_port,
           out_valid, out_flit, fifo_count, err
  );

  modport master (
    output in_valid, in_flit, route_sel, grant,
    input  credit_out, dst_x, dst_y, req_valid, req_port,
           out_valid, out_flit, fifo_count, err
  );
endinterface
`default_nettype wire

// File: rtl/input_unit.sv
`default_nettype none
// ============================================================================
// input_unit : per-port router input stage (credit FIFO, route latch, SA request)
// Build option: INPUT_UNIT_ERR_EN implements sticky err flags.   Rev 1.0
// ============================================================================
module input_unit #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        route_q, route_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;

  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic              empty, full, is_head, req_valid;
  logic              grant_pop, discard, pop, push;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_type = head[FLIT_W-1 -: 2];
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    is_head   = head_type[0];
    req_valid = (state_q == ACTIVE) && !empty;
    grant_pop = req_valid && bus.grant;
    // A non-head flit at the head while idle can never be routed; drop it.
    discard   = (state_q == IDLE) && !empty && !is_head;
    pop       = grant_pop || discard;
    push      = bus.in_valid && (!full || pop);
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && is_head) begin
          route_d = bus.route_sel;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (grant_pop && head_type[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_flit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = grant_pop;
    out_flit_d  = grant_pop ? head : out_flit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      route_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      route_q     <= route_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

`ifdef INPUT_UNIT_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q | {discard, bus.in_valid && full && !pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 2'b00;
`endif

  assign bus.credit_out = pop;
  assign bus.dst_x      = head[FLIT_W-3 -: 3];
  assign bus.dst_y      = head[FLIT_W-6 -: 3];
  assign bus.req_valid  = req_valid;
  assign bus.req_port   = route_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_flit   = out_flit_q;
  assign bus.fifo_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_input_unit.sv
`default_nettype none
// ============================================================================
// tb_input_unit : directed scenarios plus randomized traffic vs a queue model
// Rev 1.0
// ============================================================================
module tb_input_unit;
  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);
`ifdef INPUT_UNIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  input_unit_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();
  input_unit #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // observed values for the most recent cycle
  logic              s_req, s_credit, s_ovalid;
  logic [2:0]        s_port, s_dx, s_dy;
  logic [FLIT_W-1:0] s_oflit;
  logic [CW-1:0]     s_count;
  logic [1:0]        s_err;

  // reference model: packet-level view of the input stage
  logic [FLIT_W-1:0] m_q[$];
  bit                m_act, m_ov, m_pr, m_ovalid;
  logic [2:0]        m_rt;
  logic [FLIT_W-1:0] m_oflit;

  // model expectations for the most recent cycle
  logic              e_req, e_credit, e_ovalid;
  logic [2:0]        e_port, e_dx, e_dy;
  logic [FLIT_W-1:0] e_oflit;
  logic [CW-1:0]     e_count;
  logic [1:0]        e_err;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [2:0] x,
                                           input logic [2:0] y, input logic [FLIT_W-9:0] p);
    return {t, x, y, p};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_act = 0; m_ov = 0; m_pr = 0; m_ovalid = 0; m_rt = '0; m_oflit = '0;
  endtask

  // One clock cycle: apply inputs, sample mid-cycle, then advance the model.
  task automatic tick(input logic v, input logic [FLIT_W-1:0] f, input logic [2:0] rs, input logic g);
    int sz;
    bit hd, gp, disc, latch;
    logic [FLIT_W-1:0] pf;
    bus.in_valid = v; bus.in_flit = f; bus.route_sel = rs; bus.grant = g;
    #2;
    s_req = bus.req_valid; s_port = bus.req_port; s_credit = bus.credit_out;
    s_ovalid = bus.out_valid; s_oflit = bus.out_flit; s_count = bus.fifo_count;
    s_dx = bus.dst_x; s_dy = bus.dst_y; s_err = bus.err;
    sz = m_q.size();
    hd = 0;
    e_dx = '0; e_dy = '0;
    if (sz != 0) begin
      hd   = m_q[0][FLIT_W-2];
      e_dx = m_q[0][FLIT_W-3 -: 3];
      e_dy = m_q[0][FLIT_W-6 -: 3];
    end
    e_req    = m_act && (sz != 0);
    gp       = e_req && g;
    disc     = !m_act && (sz != 0) && !hd;
    latch    = !m_act && (sz != 0) && hd;
    e_credit = gp || disc;
    e_port   = m_rt;
    e_count  = CW'(sz);
    e_ovalid = m_ovalid;
    e_oflit  = m_oflit;
    e_err    = ERR_EN ? {m_pr, m_ov} : 2'b00;
    @(posedge clk); #1;
    m_ovalid = gp;
    if (gp || disc) begin
      pf = m_q.pop_front();
      if (gp) begin
        m_oflit = pf;
        if (pf[FLIT_W-1]) m_act = 0;
      end else begin
        m_pr = 1;
      end
    end
    if (latch) begin m_act = 1; m_rt = rs; end
    if (v) begin
      if (sz < DEPTH || gp || disc) m_q.push_back(f);
      else m_ov = 1;
    end
    cyc++;
  endtask

  task automatic assert_reset();
    bus.in_valid = 0; bus.in_flit = '0; bus.route_sel = '0; bus.grant = 0;
    rst_n = 1'b0;
    m_reset();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    assert_reset();
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if ({bus.out_valid, bus.out_flit, bus.fifo_count, bus.err, bus.credit_out, bus.req_valid, bus.req_port}
        !== {1'b0, {FLIT_W{1'b0}}, {CW{1'b0}}, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%0b flit=%h cnt=%0d err=%b cr=%0b req=%0b port=%0d want all zero",
               bus.out_valid, bus.out_flit, bus.fifo_count, bus.err, bus.credit_out, bus.req_valid, bus.req_port);
    end
    release_reset();
  endtask

  task automatic test_single();
    logic [FLIT_W-1:0] f;
    int credits;
    f = mk(T_HT, 3'd5, 3'd6, 24'hA1B2C3);
    credits = 0;
    tick(1, f, 3'd2, 1);
    credits += int'(s_credit);
    n_chk++;
    if ({s_req, s_count} !== {1'b0, CW'(0)}) begin
      n_err++; $display("FAIL single_n: got req=%0b cnt=%0d want 0 0", s_req, s_count);
    end
    tick(0, '0, 3'd2, 1);
    credits += int'(s_credit);
    n_chk++;
    if ({s_req, s_count, s_dx, s_dy} !== {1'b0, CW'(1), 3'd5, 3'd6}) begin
      n_err++; $display("FAIL single_n1: got req=%0b cnt=%0d dx=%0d dy=%0d want 0 1 5 6", s_req, s_count, s_dx, s_dy);
    end
    tick(0, '0, 3'd2, 1);
    credits += int'(s_credit);
    n_chk++;
    if ({s_req, s_port, s_ovalid} !== {1'b1, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL single_n2: got req=%0b port=%0d ov=%0b want 1 2 0", s_req, s_port, s_ovalid);
    end
    tick(0, '0, 3'd0, 0);
    credits += int'(s_credit);
    n_chk++;
    if ({s_ovalid, s_oflit, s_req, s_count} !== {1'b1, f, 1'b0, CW'(0)}) begin
      n_err++; $display("FAIL single_n3: got ov=%0b flit=%h req=%0b cnt=%0d want 1 %h 0 0", s_ovalid, s_oflit, s_req, s_count, f);
    end
    tick(1, mk(T_HT, 3'd1, 3'd1, 24'h0), 3'd6, 0);
    tick(0, '0, 3'd6, 0);
    n_chk++;
    if (credits !== 1 || s_req !== 1'b0 || s_port !== 3'd2) begin
      n_err++; $display("FAIL single_idle: got credits=%0d req=%0b port=%0d want 1 0 2", credits, s_req, s_port);
    end
    tick(0, '0, 3'd6, 1);
    tick(0, '0, 3'd0, 0);
  endtask

  task automatic test_stall();
    logic [FLIT_W-1:0] h, b, t;
    int credits;
    h = mk(T_HEAD, 3'd2, 3'd3, 24'h111111);
    b = mk(T_BODY, 3'd0, 3'd0, 24'h222222);
    t = mk(T_TAIL, 3'd0, 3'd0, 24'h333333);
    credits = 0;
    tick(1, h, 3'd5, 0);
    tick(1, b, 3'd5, 0);
    tick(1, t, 3'd0, 0);
    n_chk++;
    if ({s_req, s_port, s_credit} !== {1'b1, 3'd5, 1'b0}) begin
      n_err++; $display("FAIL stall_1: got req=%0b port=%0d cr=%0b want 1 5 0", s_req, s_port, s_credit);
    end
    tick(0, '0, 3'd0, 0);
    n_chk++;
    if ({s_req, s_credit, s_count} !== {1'b1, 1'b0, CW'(3)}) begin
      n_err++; $display("FAIL stall_2: got req=%0b cr=%0b cnt=%0d want 1 0 3", s_req, s_credit, s_count);
    end
    tick(0, '0, 3'd0, 1); credits += int'(s_credit);
    tick(0, '0, 3'd0, 1); credits += int'(s_credit);
    n_chk++;
    if ({s_ovalid, s_oflit} !== {1'b1, h}) begin
      n_err++; $display("FAIL stall_out0: got ov=%0b flit=%h want 1 %h", s_ovalid, s_oflit, h);
    end
    tick(0, '0, 3'd0, 1); credits += int'(s_credit);
    n_chk++;
    if ({s_ovalid, s_oflit} !== {1'b1, b}) begin
      n_err++; $display("FAIL stall_out1: got ov=%0b flit=%h want 1 %h", s_ovalid, s_oflit, b);
    end
    tick(0, '0, 3'd0, 0); credits += int'(s_credit);
    n_chk++;
    if ({s_ovalid, s_oflit, s_req, s_count} !== {1'b1, t, 1'b0, CW'(0)} || credits !== 3) begin
      n_err++; $display("FAIL stall_out2: got ov=%0b flit=%h req=%0b cnt=%0d credits=%0d want 1 %h 0 0 3",
                        s_ovalid, s_oflit, s_req, s_count, credits, t);
    end
  endtask

  task automatic test_back_to_back();
    logic [FLIT_W-1:0] h1, t1, h2, t2;
    h1 = mk(T_HEAD, 3'd1, 3'd0, 24'hAAAA01);
    t1 = mk(T_TAIL, 3'd0, 3'd0, 24'hAAAA02);
    h2 = mk(T_HEAD, 3'd4, 3'd4, 24'hBBBB01);
    t2 = mk(T_TAIL, 3'd0, 3'd0, 24'hBBBB02);
    tick(1, h1, 3'd1, 1);
    tick(1, t1, 3'd1, 1);
    tick(1, h2, 3'd4, 1);
    tick(1, t2, 3'd4, 1);
    n_chk++;
    if ({s_req, s_port, s_ovalid, s_oflit} !== {1'b1, 3'd1, 1'b1, h1}) begin
      n_err++; $display("FAIL b2b_tail1: got req=%0b port=%0d ov=%0b flit=%h want 1 1 1 %h", s_req, s_port, s_ovalid, s_oflit, h1);
    end
    tick(0, '0, 3'd4, 1);
    n_chk++;
    if ({s_req, s_credit, s_ovalid, s_oflit} !== {1'b0, 1'b0, 1'b1, t1}) begin
      n_err++; $display("FAIL b2b_bubble: got req=%0b cr=%0b ov=%0b flit=%h want 0 0 1 %h", s_req, s_credit, s_ovalid, s_oflit, t1);
    end
    tick(0, '0, 3'd4, 1);
    n_chk++;
    if ({s_req, s_port, s_ovalid} !== {1'b1, 3'd4, 1'b0}) begin
      n_err++; $display("FAIL b2b_head2: got req=%0b port=%0d ov=%0b want 1 4 0", s_req, s_port, s_ovalid);
    end
    tick(0, '0, 3'd0, 1);
    tick(0, '0, 3'd0, 0);
    n_chk++;
    if ({s_ovalid, s_oflit, s_req} !== {1'b1, t2, 1'b0}) begin
      n_err++; $display("FAIL b2b_tail2: got ov=%0b flit=%h req=%0b want 1 %h 0", s_ovalid, s_oflit, s_req, t2);
    end
  endtask

  task automatic test_overflow();
    logic [FLIT_W-1:0] seq [5];
    logic [FLIT_W-1:0] lost;
    seq[0] = mk(T_HEAD, 3'd7, 3'd7, 24'hC00000);
    for (int i = 1; i < 4; i++) seq[i] = mk(T_BODY, 3'd0, 3'd0, 24'hC00000 + 24'(i));
    seq[4] = mk(T_TAIL, 3'd0, 3'd0, 24'hC0000F);
    lost   = mk(T_BODY, 3'd0, 3'd0, 24'hDEAD00);
    for (int i = 0; i < 4; i++) tick(1, seq[i], 3'd7, 0);
    tick(1, lost, 3'd7, 0);
    n_chk++;
    if ({s_count, s_err} !== {CW'(4), 2'b00}) begin
      n_err++; $display("FAIL ovf_full: got cnt=%0d err=%b want 4 00", s_count, s_err);
    end
    tick(1, seq[4], 3'd7, 1);
    n_chk++;
    if ({s_count, s_err, s_credit} !== {CW'(4), (ERR_EN ? 2'b01 : 2'b00), 1'b1}) begin
      n_err++; $display("FAIL ovf_drop: got cnt=%0d err=%b cr=%0b want 4 %b 1", s_count, s_err, s_credit, ERR_EN ? 2'b01 : 2'b00);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, '0, 3'd7, i < 4);
      n_chk++;
      if ({s_ovalid, s_oflit} !== {1'b1, seq[i]} || (i == 0 && s_count !== CW'(4)) || (i == 4 && s_count !== CW'(0))) begin
        n_err++; $display("FAIL ovf_drain%0d: got ov=%0b flit=%h cnt=%0d want 1 %h", i, s_ovalid, s_oflit, s_count, seq[i]);
      end
    end
  endtask

  task automatic test_discard();
    tick(1, mk(T_BODY, 3'd2, 3'd2, 24'h5A5A5A), 3'd3, 0);
    tick(0, '0, 3'd3, 1);
    n_chk++;
    if ({s_credit, s_req, s_count} !== {1'b1, 1'b0, CW'(1)}) begin
      n_err++; $display("FAIL discard_pop: got cr=%0b req=%0b cnt=%0d want 1 0 1", s_credit, s_req, s_count);
    end
    tick(0, '0, 3'd3, 1);
    n_chk++;
    if ({s_credit, s_req, s_count, s_ovalid, s_err} !== {1'b0, 1'b0, CW'(0), 1'b0, (ERR_EN ? 2'b11 : 2'b00)}) begin
      n_err++; $display("FAIL discard_after: got cr=%0b req=%0b cnt=%0d ov=%0b err=%b want 0 0 0 0 %b",
                        s_credit, s_req, s_count, s_ovalid, s_err, ERR_EN ? 2'b11 : 2'b00);
    end
  endtask

  task automatic test_reset_mid();
    logic [FLIT_W-1:0] h;
    h = mk(T_HEAD, 3'd3, 3'd1, 24'h777777);
    tick(1, h, 3'd3, 1);
    tick(1, mk(T_BODY, 3'd0, 3'd0, 24'h777778), 3'd3, 1);
    tick(1, mk(T_TAIL, 3'd0, 3'd0, 24'h777779), 3'd3, 1);
    assert_reset();
    n_chk++;
    if ({bus.out_valid, bus.out_flit, bus.fifo_count, bus.err, bus.credit_out, bus.req_valid, bus.req_port}
        !== {1'b0, {FLIT_W{1'b0}}, {CW{1'b0}}, 2'b00, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid: got ov=%0b flit=%h cnt=%0d err=%b cr=%0b req=%0b port=%0d want all zero",
               bus.out_valid, bus.out_flit, bus.fifo_count, bus.err, bus.credit_out, bus.req_valid, bus.req_port);
    end
    release_reset();
    h = mk(T_HT, 3'd6, 3'd2, 24'h888888);
    tick(1, h, 3'd6, 1);
    tick(0, '0, 3'd6, 1);
    tick(0, '0, 3'd0, 1);
    n_chk++;
    if ({s_req, s_port, s_credit} !== {1'b1, 3'd6, 1'b1}) begin
      n_err++; $display("FAIL reset_route: got req=%0b port=%0d cr=%0b want 1 6 1", s_req, s_port, s_credit);
    end
    tick(0, '0, 3'd0, 0);
    n_chk++;
    if ({s_ovalid, s_oflit} !== {1'b1, h}) begin
      n_err++; $display("FAIL reset_out: got ov=%0b flit=%h want 1 %h", s_ovalid, s_oflit, h);
    end
  endtask

  task automatic test_random();
    logic v, g;
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 99) < 60);
      g = ($urandom_range(0, 99) < 55);
      f = mk(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 24'($urandom));
      tick(v, f, 3'($urandom), g);
      n_chk++;
      if ({s_req, s_credit, s_count, s_ovalid, s_oflit, s_err} !== {e_req, e_credit, e_count, e_ovalid, e_oflit, e_err}) begin
        n_err++;
        $display("FAIL rand_c%0d: got req=%0b cr=%0b cnt=%0d ov=%0b flit=%h err=%b want %0b %0b %0d %0b %h %b",
                 cyc, s_req, s_credit, s_count, s_ovalid, s_oflit, s_err,
                 e_req, e_credit, e_count, e_ovalid, e_oflit, e_err);
      end
      if (e_req) begin
        n_chk++;
        if (s_port !== e_port) begin
          n_err++; $display("FAIL rand_port_c%0d: got %0d want %0d", cyc, s_port, e_port);
        end
      end
      if (e_count != 0) begin
        n_chk++;
        if ({s_dx, s_dy} !== {e_dx, e_dy}) begin
          n_err++; $display("FAIL rand_dst_c%0d: got %0d,%0d want %0d,%0d", cyc, s_dx, s_dy, e_dx, e_dy);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_flit = '0; bus.route_sel = '0; bus.grant = 0;
    m_reset();
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_discard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
